stream_replicator: RTL
======================

# stream_replicator

Parametrised successor to the team's combinational replication-operator block. It accepts one DW-bit word with a runtime repeat count over a valid/ready handshake. It then does two things: emits the word serially that many times on an output stream, and presents a registered wide lane-replicated copy of it. It sits between a word source and a wide-bus or burst consumer, where a fixed `{N{x}}` operator is not enough.

## Interface
- `DW`, 8: data word width, ≥1.
- `MAX_REP`, 16: maximum repeat count, ≥1.
- `CW`, `$clog2(MAX_REP+1)`: count/index width (derived, not overridden).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: input word offered.
- `in_ready`  out  1: block can accept.
- `in_data`  in  DW: word to replicate.
- `in_rep`  in  CW: requested repeat count.
- `out_valid`  out  1: serial output word valid.
- `out_ready`  in  1: consumer accepts output word.
- `out_data`  out  DW: current serial copy.
- `out_idx`  out  CW: index of current copy, 0-based.
- `out_last`  out  1: current copy is the final one.
- `repl_word`  out  DW*MAX_REP: lane-replicated image of last accepted word.
- `zero_drop`  out  1: one-cycle pulse, a word with `in_rep`==0 was accepted and discarded.
- `word_cnt`  out  32: only with `STREAM_REPLICATOR_CNT_EN`; total serial handshakes completed.

## Operation
- FSM states IDLE, EMIT.
  - Reset state is IDLE.
  - `in_ready` = (state==IDLE).
- Accept = `in_valid & in_ready`. Outcomes:
  - `in_rep`==0: word discarded, `zero_drop` pulses next cycle, state stays IDLE, `repl_word` unchanged.
  - 1..MAX_REP: latch `in_data` and count, clear index, go EMIT.
  - >MAX_REP: count clamped to MAX_REP.
- EMIT outputs:
  - `out_valid`=1.
  - `out_data`=latched word.
  - `out_idx`=index.
  - `out_last`=(index==count-1).
- EMIT transitions:
  - Output handshake (`out_valid & out_ready`): index+1. If `out_last`, go IDLE.
  - `out_ready` low: outputs hold stable, no change to any output.
- `repl_word` is registered at every accept with count≥1.
  - Lane i (bits i*DW+:DW) = `in_data` for i < clamped count, else zero.
  - Lane 0 is least significant.
  - Held until the next non-zero accept.
- Index and count arithmetic is unsigned, CW bits, no wrap possible because the count is clamped.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `repl_word`=0, `zero_drop`=0, `word_cnt`=0.
- Accept at edge N gives `out_valid`=1 and valid `repl_word` in the cycle after edge N (1-cycle latency).
- Final handshake at edge M gives `in_ready`=1 after edge M. There is always one bubble; no accept occurs in the same cycle as the last output.
- Best-case throughput: count+1 cycles per input word.
- Reset mid-EMIT: state returns to IDLE immediately, the remaining copies and the latched word are lost, and all outputs go to their reset values.
- `in_valid` while busy: ignored. The source must hold the word until `in_ready`.

## Configuration
- Macro `STREAM_REPLICATOR_CNT_EN`.
- Defined: the `word_cnt` port and a 32-bit counter are present.
  - Counter increments on every output handshake and wraps modulo 2^32.
  - Cleared only by `rst`.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared package `stream_replicator_pkg` contains:
  - the FSM state enum (IDLE, EMIT);
  - the clamp function `rep_clamp(count, max)`;
  - the lane-mask generator used to build `repl_word`.
- One natural sub-module, `lane_replicator`: combinational {data, count} → DW*MAX_REP masked replicated word. The top module registers its output.

## Test plan
- Reset: assert `rst` for 2 cycles → all outputs at reset values, `in_ready`=1.
- DW=8, MAX_REP=16, accept 0xA5 with rep=3, `out_ready`=1 → `out_valid` for exactly 3 cycles with idx 0,1,2; `out_last` only at idx 2; `repl_word` lanes 0–2=0xA5, lanes 3–15=0; `in_ready` returns 1 after the bubble.
- Backpressure: rep=4, `out_ready` toggling 1,0,0,1,… → each copy held stable while stalled, 4 handshakes in total, no index skipped.
- Boundaries:
  - rep=0 → `zero_drop` pulse, no `out_valid`, `repl_word` unchanged.
  - rep=20 → clamped, 16 copies, all 16 lanes filled.
- Reset mid-operation: `rst` after the 2nd of 5 copies → `out_valid`=0 immediately; a new word with rep=1 afterwards emits one copy with idx 0.
- With `STREAM_REPLICATOR_CNT_EN`: words with rep 3 then 2 → `word_cnt`=5. The build without the macro compiles with no `word_cnt` port.

Source files
------------

// File: rtl/stream_replicator_pkg.sv
// Shared types and helpers for stream_replicator: FSM state encoding, repeat-count
// clamp and the per-lane enable used to build the lane-replicated word.
package stream_replicator_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic int unsigned rep_clamp(input int unsigned count, input int unsigned max);
        return (count > max) ? max : count;
    endfunction

    // Lane-mask generator: lane is populated when it lies below the clamped count.
    function automatic logic lane_on(input int unsigned lane, input int unsigned count);
        return lane < count;
    endfunction

endpackage

// File: rtl/stream_replicator_if.sv
// Handshake bundle for stream_replicator: input word channel and serial output channel.
// A transfer happens on a rising edge where valid and ready are both high; the sender
// holds valid and its payload stable until that edge.
interface stream_replicator_if #(
    parameter int unsigned DW      = 8,
    parameter int unsigned MAX_REP = 16
);
    localparam int unsigned CW = $clog2(MAX_REP + 1);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_rep;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_idx;
    logic          out_last;

    modport master (
        output in_valid, in_data, in_rep, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, in_rep, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/stream_replicator_lane_replicator.sv
// Combinational lane replicator: copies data into the lowest 'count' lanes of a
// DW*MAX_REP word and zeroes the rest (lane 0 least significant).
module lane_replicator
    import stream_replicator_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned MAX_REP = 16,
    localparam int unsigned CW     = $clog2(MAX_REP + 1)
) (
    input  logic [DW-1:0]         data,
    input  logic [CW-1:0]         count,
    output logic [DW*MAX_REP-1:0] repl
);

    for (genvar i = 0; i < int'(MAX_REP); i++) begin : g_lane
        assign repl[i*DW +: DW] = lane_on(unsigned'(i), 32'(count)) ? data : '0;
    end

endmodule

// File: rtl/stream_replicator.sv
// Accepts a word plus repeat count, emits it serially count times and registers a
// lane-replicated image. Optional handshake counter under STREAM_REPLICATOR_CNT_EN.
module stream_replicator
    import stream_replicator_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned MAX_REP = 16,
    localparam int unsigned CW     = $clog2(MAX_REP + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    stream_replicator_if.slave     bus,
    output logic [DW*MAX_REP-1:0]  repl_word,
    output logic                   zero_drop,
`ifdef STREAM_REPLICATOR_CNT_EN
    output logic [31:0]            word_cnt,
`endif
    output state_e                 dbg_state
);

    state_e                 state_q, state_d;
    logic [DW-1:0]          data_q, data_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          idx_q, idx_d;
    logic                   last_q, last_d;
    logic                   valid_q, valid_d;
    logic                   zd_q, zd_d;
    logic [DW*MAX_REP-1:0]  repl_q, repl_d;
    logic [DW*MAX_REP-1:0]  lane_img;
    logic [CW-1:0]          rep_clamped;
    logic                   accept;
    logic                   out_fire;

    assign rep_clamped = CW'(rep_clamp(32'(bus.in_rep), MAX_REP));
    assign accept      = bus.in_valid && (state_q == IDLE);
    assign out_fire    = valid_q && bus.out_ready;

    lane_replicator #(
        .DW      (DW),
        .MAX_REP (MAX_REP)
    ) u_lane (
        .data  (bus.in_data),
        .count (rep_clamped),
        .repl  (lane_img)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        repl_d  = repl_q;
        zd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (rep_clamped == '0) begin
                        zd_d = 1'b1;
                    end else begin
                        state_d = EMIT;
                        data_d  = bus.in_data;
                        cnt_d   = rep_clamped;
                        idx_d   = '0;
                        last_d  = (rep_clamped == CW'(1));
                        valid_d = 1'b1;
                        repl_d  = lane_img;
                    end
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (last_q) begin
                        // Returning to IDLE forces the one-cycle bubble before the next accept.
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = '0;
                    end else begin
                        idx_d  = idx_q + CW'(1);
                        last_d = (idx_q + CW'(1)) == (cnt_q - CW'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            zd_q    <= 1'b0;
            repl_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            zd_q    <= zd_d;
            repl_q  <= repl_d;
        end
    end

`ifdef STREAM_REPLICATOR_CNT_EN
    logic [31:0] wc_q, wc_d;

    always_comb begin
        wc_d = wc_q;
        if (out_fire) wc_d = wc_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wc_q <= '0;
        else     wc_q <= wc_d;
    end

    assign word_cnt = wc_q;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign repl_word     = repl_q;
    assign zero_drop     = zd_q;
    assign dbg_state     = state_q;

endmodule
